// File: rtl/branch_pkg.sv
// Shared types and sizing for the fetch-side branch predictor.
// The BTB entry layout is fixed by the default 32-bit PC / 64-entry geometry.
package branch_pkg;

  localparam int BP_DATA_WIDTH = 32;
  localparam int BP_INDEX_BITS = 6;
  localparam int BP_TAG_BITS   = BP_DATA_WIDTH - BP_INDEX_BITS - 2;
  localparam int BP_DEPTH      = 1 << BP_INDEX_BITS;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_t;

  typedef struct packed {
    logic                     valid;
    logic [BP_TAG_BITS-1:0]   tag;
    logic [BP_DATA_WIDTH-1:0] target;
  } btb_entry_t;

  localparam bp_ctr_t CTR_RESET = WNT;

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-state function used on the BHT update path.
module bp_sat_counter
  import branch_pkg::*;
(
  input  bp_ctr_t ctr,
  input  logic    taken,
  output bp_ctr_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != ST) ctr_next = bp_ctr_t'(ctr + 2'b01);
    end else begin
      if (ctr != SNT) ctr_next = bp_ctr_t'(ctr - 2'b01);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT + tagged BTB predictor: combinational lookup at IF, training and
// registered flush/redirect from the resolved branch at EX, saturating statistics.
module branch_predictor
  import branch_pkg::*;
(
  input  logic                     clk,
  input  logic                     rstN,
  input  logic [BP_DATA_WIDTH-1:0] if_pc,
  output logic                     pred_taken,
  output logic [BP_DATA_WIDTH-1:0] pred_target,
  input  logic                     upd_valid,
  input  logic [BP_DATA_WIDTH-1:0] upd_pc,
  input  logic                     upd_taken,
  input  logic [BP_DATA_WIDTH-1:0] upd_target,
  input  logic                     upd_pred_taken,
  input  logic [BP_DATA_WIDTH-1:0] upd_pred_target,
  output logic                     flush,
  output logic [BP_DATA_WIDTH-1:0] redirect_pc,
  output logic [31:0]              branch_count,
  output logic [31:0]              miss_count
);

  localparam int DW = BP_DATA_WIDTH;
  localparam int IB = BP_INDEX_BITS;
  localparam logic [DW-1:0] PC_STEP = DW'(4);

  bp_ctr_t    ctr_q [BP_DEPTH];
  btb_entry_t btb_q [BP_DEPTH];

  logic [IB-1:0]          lk_idx, up_idx;
  logic [BP_TAG_BITS-1:0] lk_tag, up_tag;
  logic                   lk_hit;
  bp_ctr_t                lk_ctr, up_ctr, up_ctr_next;
  logic                   mispredict;
  logic                   unused_pc_lsbs;

  assign lk_idx = if_pc[IB+1:2];
  assign lk_tag = if_pc[DW-1:IB+2];
  assign up_idx = upd_pc[IB+1:2];
  assign up_tag = upd_pc[DW-1:IB+2];
  assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0]};

  // Lookup reads the registered tables, so a same-cycle update is not visible yet.
  assign lk_ctr      = ctr_q[lk_idx];
  assign lk_hit      = btb_q[lk_idx].valid && (btb_q[lk_idx].tag == lk_tag);
  assign pred_taken  = lk_hit && ((lk_ctr == WT) || (lk_ctr == ST));
  assign pred_target = pred_taken ? btb_q[lk_idx].target : (if_pc + PC_STEP);

  assign up_ctr = ctr_q[up_idx];

  bp_sat_counter u_sat_counter (
    .ctr      (up_ctr),
    .taken    (upd_taken),
    .ctr_next (up_ctr_next)
  );

  assign mispredict = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_pred_target != upd_target)));

  always_ff @(posedge clk) begin
    if (!rstN) begin
      for (int i = 0; i < BP_DEPTH; i++) begin
        ctr_q[i] <= CTR_RESET;
        btb_q[i] <= '0;
      end
      flush        <= 1'b0;
      redirect_pc  <= '0;
      branch_count <= '0;
      miss_count   <= '0;
    end else begin
      flush <= mispredict;
      if (mispredict) begin
        redirect_pc <= upd_taken ? upd_target : (upd_pc + PC_STEP);
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end
      if (upd_valid) begin
        ctr_q[up_idx] <= up_ctr_next;
        if (upd_taken) btb_q[up_idx] <= '{valid: 1'b1, tag: up_tag, target: upd_target};
        if (branch_count != 32'hFFFF_FFFF) branch_count <= branch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed table-driven bench for branch_predictor: each row drives one cycle of inputs,
// checks the pre-edge prediction, then the registered outputs after the edge.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rstN;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] miss_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk             (clk),
    .rstN            (rstN),
    .if_pc           (if_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .flush           (flush),
    .redirect_pc     (redirect_pc),
    .branch_count    (branch_count),
    .miss_count      (miss_count)
  );

  typedef struct {
    bit          rst_n;
    bit [31:0]   ifpc;
    bit          uv;
    bit [31:0]   upc;
    bit          ut;
    bit [31:0]   utgt;
    bit          upt;
    bit [31:0]   uptgt;
    bit          chk_pred;
    bit          e_pt;
    bit [31:0]   e_ptgt;
    bit          e_fl;
    bit [31:0]   e_rd;
    bit [31:0]   e_bc;
    bit [31:0]   e_mc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst_n, bit [31:0] ifpc, bit uv, bit [31:0] upc, bit ut,
                              bit [31:0] utgt, bit upt, bit [31:0] uptgt, bit chk_pred,
                              bit e_pt, bit [31:0] e_ptgt, bit e_fl, bit [31:0] e_rd,
                              bit [31:0] e_bc, bit [31:0] e_mc);
    vec_t v;
    v.rst_n = rst_n; v.ifpc = ifpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.upt = upt; v.uptgt = uptgt; v.chk_pred = chk_pred; v.e_pt = e_pt; v.e_ptgt = e_ptgt;
    v.e_fl = e_fl; v.e_rd = e_rd; v.e_bc = e_bc; v.e_mc = e_mc;
    return v;
  endfunction

  task automatic check32(string name, int row, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got 0x%08h expected 0x%08h", name, row, act, exp);
    end
  endtask

  initial begin
    //                 rst ifpc          uv upc           ut utgt          upt uptgt        chk pt ptgt          fl rd            bc  mc
    vecs.push_back(mk(0, 32'h100,       0, 32'h0,        0, 32'h0,        0, 32'h0,   0, 0, 32'h0,        0, 32'h0,        0, 0));
    vecs.push_back(mk(1, 32'h100,       0, 32'h0,        0, 32'h0,        0, 32'h0,   1, 0, 32'h104,      0, 32'h0,        0, 0));
    vecs.push_back(mk(1, 32'h100,       1, 32'h100,      1, 32'h200,      0, 32'h104, 1, 0, 32'h104,      1, 32'h200,      1, 1));
    vecs.push_back(mk(1, 32'h100,       1, 32'h100,      1, 32'h200,      0, 32'h104, 1, 1, 32'h200,      1, 32'h200,      2, 2));
    vecs.push_back(mk(1, 32'h100,       0, 32'h0,        0, 32'h0,        0, 32'h0,   1, 1, 32'h200,      0, 32'h200,      2, 2));
    vecs.push_back(mk(1, 32'h100,       1, 32'h100,      0, 32'h0,        1, 32'h200, 1, 1, 32'h200,      1, 32'h104,      3, 3));
    vecs.push_back(mk(1, 32'h100,       0, 32'h0,        0, 32'h0,        0, 32'h0,   1, 1, 32'h200,      0, 32'h104,      3, 3));
    vecs.push_back(mk(1, 32'h100,       1, 32'h100,      0, 32'h0,        1, 32'h200, 1, 1, 32'h200,      1, 32'h104,      4, 4));
    vecs.push_back(mk(1, 32'h100,       0, 32'h0,        0, 32'h0,        0, 32'h0,   1, 0, 32'h104,      0, 32'h104,      4, 4));
    vecs.push_back(mk(1, 32'h100,       1, 32'h100,      1, 32'h200,      1, 32'h200, 1, 0, 32'h104,      0, 32'h104,      5, 4));
    vecs.push_back(mk(1, 32'h100,       1, 32'h100,      1, 32'h240,      1, 32'h200, 1, 1, 32'h200,      1, 32'h240,      6, 5));
    vecs.push_back(mk(1, 32'h100,       0, 32'h0,        0, 32'h0,        0, 32'h0,   1, 1, 32'h240,      0, 32'h240,      6, 5));
    vecs.push_back(mk(1, 32'h1100,      0, 32'h0,        0, 32'h0,        0, 32'h0,   1, 0, 32'h1104,     0, 32'h240,      6, 5));
    vecs.push_back(mk(1, 32'h1100,      1, 32'h1100,     1, 32'h300,      0, 32'h0,   1, 0, 32'h1104,     1, 32'h300,      7, 6));
    vecs.push_back(mk(1, 32'h100,       0, 32'h0,        0, 32'h0,        0, 32'h0,   1, 0, 32'h104,      0, 32'h300,      7, 6));
    vecs.push_back(mk(1, 32'h1100,      0, 32'h0,        0, 32'h0,        0, 32'h0,   1, 1, 32'h300,      0, 32'h300,      7, 6));
    vecs.push_back(mk(1, 32'h1100,      1, 32'h1100,     1, 32'h300,      1, 32'h300, 1, 1, 32'h300,      0, 32'h300,      8, 6));
    vecs.push_back(mk(1, 32'hFFFF_FFFC, 0, 32'h0,        0, 32'h0,        0, 32'h0,   1, 0, 32'h0,        0, 32'h300,      8, 6));
    vecs.push_back(mk(1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC,0, 32'h0,        1, 32'h10,  1, 0, 32'h0,        1, 32'h0,        9, 7));
    vecs.push_back(mk(1, 32'h1100,      0, 32'h100,      1, 32'h999,      0, 32'h0,   1, 1, 32'h300,      0, 32'h0,        9, 7));
    vecs.push_back(mk(1, 32'h104,       1, 32'h104,      1, 32'h500,      0, 32'h0,   1, 0, 32'h108,      1, 32'h500,     10, 8));
    vecs.push_back(mk(1, 32'h104,       0, 32'h0,        0, 32'h0,        0, 32'h0,   1, 1, 32'h500,      0, 32'h500,     10, 8));
    vecs.push_back(mk(0, 32'h104,       1, 32'h104,      1, 32'h600,      0, 32'h0,   1, 1, 32'h500,      0, 32'h0,        0, 0));
    vecs.push_back(mk(1, 32'h104,       0, 32'h0,        0, 32'h0,        0, 32'h0,   1, 0, 32'h108,      0, 32'h0,        0, 0));
    vecs.push_back(mk(1, 32'h1100,      0, 32'h0,        0, 32'h0,        0, 32'h0,   1, 0, 32'h1104,     0, 32'h0,        0, 0));
    vecs.push_back(mk(1, 32'h104,       1, 32'h104,      1, 32'h700,      0, 32'h0,   1, 0, 32'h108,      1, 32'h700,      1, 1));
    vecs.push_back(mk(1, 32'h104,       0, 32'h0,        0, 32'h0,        0, 32'h0,   1, 1, 32'h700,      0, 32'h700,      1, 1));
    vecs.push_back(mk(1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC,0, 32'h0,        0, 32'h0,   1, 0, 32'h0,        0, 32'h700,      2, 1));
    vecs.push_back(mk(1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC,0, 32'h0,        0, 32'h0,   1, 0, 32'h0,        0, 32'h700,      3, 1));
    vecs.push_back(mk(1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC,1, 32'h40,       0, 32'h0,   1, 0, 32'h0,        1, 32'h40,       4, 2));
    vecs.push_back(mk(1, 32'hFFFF_FFFC, 0, 32'h0,        0, 32'h0,        0, 32'h0,   1, 0, 32'h0,        0, 32'h40,       4, 2));

    for (int r = 0; r < vecs.size(); r++) begin
      rstN            = vecs[r].rst_n;
      if_pc           = vecs[r].ifpc;
      upd_valid       = vecs[r].uv;
      upd_pc          = vecs[r].upc;
      upd_taken       = vecs[r].ut;
      upd_target      = vecs[r].utgt;
      upd_pred_taken  = vecs[r].upt;
      upd_pred_target = vecs[r].uptgt;
      #1;
      if (vecs[r].chk_pred) begin
        check32("pred_taken", r, {31'b0, pred_taken}, {31'b0, vecs[r].e_pt});
        check32("pred_target", r, pred_target, vecs[r].e_ptgt);
      end
      @(posedge clk);
      #1;
      check32("flush", r, {31'b0, flush}, {31'b0, vecs[r].e_fl});
      check32("redirect_pc", r, redirect_pc, vecs[r].e_rd);
      check32("branch_count", r, branch_count, vecs[r].e_bc);
      check32("miss_count", r, miss_count, vecs[r].e_mc);
    end

    // Three consecutive mispredicts on one index keep flush high every cycle,
    // with redirect following each branch, then flush drops once updates stop.
    upd_valid = 1'b1; upd_pc = 32'h204; upd_taken = 1'b1; upd_pred_taken = 1'b0;
    upd_pred_target = 32'h0;
    for (int k = 0; k < 3; k++) begin
      upd_target = 32'h800 + 32'(k) * 32'h10;
      @(posedge clk);
      #1;
      check32("b2b_flush", k, {31'b0, flush}, 32'd1);
      check32("b2b_redirect", k, redirect_pc, 32'h800 + 32'(k) * 32'h10);
      check32("b2b_miss", k, miss_count, 32'd3 + 32'(k));
    end
    upd_valid = 1'b0; if_pc = 32'h204;
    #1;
    check32("b2b_pred_target", 0, pred_target, 32'h820);
    @(posedge clk);
    #1;
    check32("b2b_flush_drop", 0, {31'b0, flush}, 32'd0);
    check32("b2b_branch", 0, branch_count, 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
